// File: rtl/drive_link_pkg.sv
// Shared definitions for the car-to-simulator command link: frame bit
// positions, frame tag and the transmitter state encoding.
package drive_link_pkg;

  localparam int FWD_BIT     = 0;
  localparam int BWD_BIT     = 1;
  localparam int LEFT_BIT    = 2;
  localparam int RIGHT_BIT   = 3;
  localparam int PLACE_BIT   = 4;
  localparam int DESTROY_BIT = 5;

  localparam logic [1:0] FRAME_TAG = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } link_state_t;

  // Assemble a command byte from its individual fields.
  function automatic logic [7:0] pack_frame(input logic fwd, input logic bwd,
                                            input logic left, input logic right,
                                            input logic place, input logic destroy);
    logic [7:0] f;
    f              = '0;
    f[FWD_BIT]     = fwd;
    f[BWD_BIT]     = bwd;
    f[LEFT_BIT]    = left;
    f[RIGHT_BIT]   = right;
    f[PLACE_BIT]   = place;
    f[DESTROY_BIT] = destroy;
    f[7:6]         = FRAME_TAG;
    return f;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running DIV-cycle counter; emits a one-clock tick at count DIV-1.
// A synchronous clear realigns the bit grid to the start of a frame.
module baud_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Count 0..DIV-1 and wrap; clear restarts the bit period at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (clear) cnt <= '0;
    else if (tick)  cnt <= '0;
    else            cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/drive_cmd_uart_tx.sv
// 8N1 transmitter for the command link. Sends a frame when the level
// commands change, when a barrier request is pending, or on refresh.
//
// state | meaning
// IDLE  | line high, waiting for a send trigger
// START | start bit (tx=0) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (tx=1); frame_done in its last cycle
module drive_cmd_uart_tx
  import drive_link_pkg::*;
#(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD           = 9600,
  parameter int REFRESH_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_forward,
  input  logic       move_backward,
  input  logic       turn_left,
  input  logic       turn_right,
  input  logic       place_barrier,
  input  logic       destroy_barrier,
  input  logic       enable,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] last_frame
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int RW  = $clog2(REFRESH_CYCLES);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
  // Barrier bits are events handled by the sticky flags, so change
  // detection looks only at the tag and the level commands.
  localparam logic [7:0] LEVEL_MASK = ~((8'd1 << PLACE_BIT) | (8'd1 << DESTROY_BIT));

  link_state_t state, state_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift;
  logic [7:0]    candidate;
  logic [RW-1:0] refresh_cnt;
  logic          place_sticky, destroy_sticky;
  logic          tx_n, load, tick;
  logic          level_changed, refresh_due, trigger;

  baud_tick_gen #(.DIV(DIV)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (load),
    .tick  (tick)
  );

  assign candidate     = pack_frame(move_forward, move_backward, turn_left, turn_right,
                                    place_sticky, destroy_sticky);
  assign level_changed = ((candidate ^ last_frame) & LEVEL_MASK) != 8'h00;
  assign refresh_due   = (refresh_cnt == REFRESH_LAST);
  assign trigger       = enable & (level_changed | refresh_due | place_sticky | destroy_sticky);
  assign busy          = (state != IDLE);

  // Next state, bit index and next registered line value.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    tx_n       = 1'b1;
    load       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_n = START;
          load    = 1'b1;
          tx_n    = 1'b0;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (tick) begin
          state_n = DATA;
          idx_n   = 3'd0;
          tx_n    = shift[0];
        end
      end
      DATA: begin
        tx_n = shift[idx];
        if (tick) begin
          if (idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            idx_n = idx + 3'd1;
            tx_n  = shift[idx + 3'd1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_n    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, bit index and registered tx line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 3'd0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      tx    <= tx_n;
    end
  end

  // Capture the frame byte at load so mid-frame input changes cannot corrupt it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift      <= 8'h00;
      last_frame <= 8'h00;
    end else if (load) begin
      shift      <= candidate;
      last_frame <= candidate;
    end
  end

  // Barrier requests stick until a frame carries them; a pulse in the load cycle re-arms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      place_sticky   <= 1'b0;
      destroy_sticky <= 1'b0;
    end else begin
      place_sticky   <= place_barrier   | (place_sticky   & ~load);
      destroy_sticky <= destroy_barrier | (destroy_sticky & ~load);
    end
  end

  // Refresh timer: saturating up-count while enabled, restarted by every load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  refresh_cnt <= '0;
    else if (!enable || load) refresh_cnt <= '0;
    else if (!refresh_due)    refresh_cnt <= refresh_cnt + RW'(1);
  end

endmodule

// File: tb/tb_drive_cmd_uart_tx.sv
// Directed bench for drive_cmd_uart_tx with DIV=10 and a 500-cycle refresh.
module tb_drive_cmd_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       move_forward = 1'b0, move_backward = 1'b0;
  logic       turn_left = 1'b0, turn_right = 1'b0;
  logic       place_barrier = 1'b0, destroy_barrier = 1'b0;
  logic       enable = 1'b0;
  logic       tx, busy, frame_done;
  logic [7:0] last_frame;

  int n_checks = 0;
  int n_fail   = 0;

  drive_cmd_uart_tx #(
    .CLK_FREQ       (1000),
    .BAUD           (100),
    .REFRESH_CYCLES (500)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .move_forward    (move_forward),
    .move_backward   (move_backward),
    .turn_left       (turn_left),
    .turn_right      (turn_right),
    .place_barrier   (place_barrier),
    .destroy_barrier (destroy_barrier),
    .enable          (enable),
    .tx              (tx),
    .busy            (busy),
    .frame_done      (frame_done),
    .last_frame      (last_frame)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of frame clk 1; returns at the negedge of frame clk 100.
  task automatic run_frame(input int place_at, input int drop_at,
                           output logic [9:0] bits, output logic fd_ok, output logic busy_ok);
    bits    = '0;
    fd_ok   = 1'b1;
    busy_ok = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      if (c % 10 == 5) bits[c/10] = tx;
      if (frame_done !== (c == 100)) fd_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      place_barrier = (c == place_at);
      if (c == drop_at) enable = 1'b0;
      if (c != 100) @(negedge clk);
    end
    place_barrier = 1'b0;
  endtask

  // Counts negedges until tx is seen low; flags any busy/frame_done while idle.
  task automatic wait_start(input int limit, output int n, output logic idle_ok);
    n       = 0;
    idle_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (tx !== 1'b0 && (busy !== 1'b0 || frame_done !== 1'b0)) idle_ok = 1'b0;
    end while (tx !== 1'b0 && n < limit);
  endtask

  logic [9:0] bits;
  logic       fd_ok, busy_ok, idle_ok, quiet;
  int         n;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_last_frame", last_frame, 8'h00);
    rst = 1'b0;

    quiet = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) quiet = 1'b0;
    end
    check("disabled_quiet", quiet, 1);

    // Change trigger, with a place_barrier pulse at frame clk 30
    enable = 1'b1;
    move_forward = 1'b1;
    wait_start(20, n, idle_ok);
    check("first_latency", n, 1);
    run_frame(30, 0, bits, fd_ok, busy_ok);
    check("f1_bits", bits, {1'b1, 8'h41, 1'b0});
    check("f1_frame_done", fd_ok, 1);
    check("f1_busy", busy_ok, 1);
    check("f1_last_frame", last_frame, 8'h41);
    @(negedge clk);
    check("f1_gap_busy", busy, 0);
    check("f1_gap_tx", tx, 1);
    @(negedge clk);
    check("f2_start_tx", tx, 0);
    check("f2_start_busy", busy, 1);
    run_frame(0, 0, bits, fd_ok, busy_ok);
    check("f2_bits", bits, {1'b1, 8'h51, 1'b0});
    check("f2_frame_done", fd_ok, 1);
    check("f2_last_frame", last_frame, 8'h51);

    // No third frame until refresh (start spacing 500 clks)
    wait_start(600, n, idle_ok);
    check("f3_refresh_gap", n, 401);
    check("f3_idle", idle_ok, 1);
    run_frame(0, 0, bits, fd_ok, busy_ok);
    check("f3_bits", bits, {1'b1, 8'h41, 1'b0});

    // Switch to left: change-triggered frame then refresh repeats
    move_forward = 1'b0;
    turn_left = 1'b1;
    wait_start(20, n, idle_ok);
    check("f4_latency", n, 2);
    run_frame(0, 0, bits, fd_ok, busy_ok);
    check("f4_bits", bits, {1'b1, 8'h44, 1'b0});
    check("f4_last_frame", last_frame, 8'h44);
    wait_start(600, n, idle_ok);
    check("f5_refresh_gap", n, 401);
    check("f5_idle", idle_ok, 1);

    // enable dropped at frame clk 40
    run_frame(0, 40, bits, fd_ok, busy_ok);
    check("f5_bits", bits, {1'b1, 8'h44, 1'b0});
    check("f5_frame_done", fd_ok, 1);
    check("f5_busy", busy_ok, 1);
    quiet = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) quiet = 1'b0;
      place_barrier = (i == 300);
    end
    place_barrier = 1'b0;
    check("disabled_after_drop", quiet, 1);

    // Sticky place flag survives while disabled
    enable = 1'b1;
    wait_start(20, n, idle_ok);
    check("f6_latency", n, 1);
    run_frame(0, 0, bits, fd_ok, busy_ok);
    check("f6_bits", bits, {1'b1, 8'h54, 1'b0});
    check("f6_last_frame", last_frame, 8'h54);

    // Async reset at frame clk 55
    move_forward = 1'b1;
    turn_left = 1'b0;
    wait_start(20, n, idle_ok);
    check("f7_latency", n, 2);
    repeat (54) @(negedge clk);
    check("f7_midframe_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_last_frame", last_frame, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_start(20, n, idle_ok);
    check("f8_latency", n, 1);
    run_frame(0, 0, bits, fd_ok, busy_ok);
    check("f8_bits", bits, {1'b1, 8'h41, 1'b0});
    check("f8_frame_done", fd_ok, 1);
    check("f8_last_frame", last_frame, 8'h41);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
